// File: rtl/ctrl_pkg.sv
// Shared decode types: control bundle, RV32I/M opcodes and ALU op codes.
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  // MUL..REMU occupy 10..17 in funct3 order, so DIV lands on 14.
  localparam logic [4:0] ALU_MUL   = 5'd10;
  localparam logic [4:0] ALU_DIV   = 5'd14;
  localparam logic [4:0] ALU_PASSB = 5'd18;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [1:0] mem_size;
    logic       mem_signed;
    logic       branch;
    logic       jump;
    logic [2:0] branch_type;
    logic       pc_target_src;
    logic [4:0] alu_ctrl;
    logic       is_div;
    logic       illegal;
  } ctrl_t;

  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_base = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_base = ALU_SLL;
      3'b010:  alu_base = ALU_SLT;
      3'b011:  alu_base = ALU_SLTU;
      3'b100:  alu_base = ALU_XOR;
      3'b101:  alu_base = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_base = ALU_OR;
      default: alu_base = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I decode (RV32M_EN adds MUL..REMU); zero latency, no backpressure.
// Illegal encodings yield illegal=1 with every other field cleared.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;
  ctrl_t      c;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    c   = '0;
    ill = 1'b0;
    case (opc)
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.alu_src_b  = 1'b1;
        c.result_src = RES_MEM;
        c.imm_src    = IMM_I;
        c.mem_size   = f3[1:0];
        c.mem_signed = ~f3[2];
        ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.imm_src   = IMM_S;
        c.mem_size  = f3[1:0];
        ill = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        c.branch      = 1'b1;
        c.imm_src     = IMM_B;
        c.branch_type = f3;
        c.alu_ctrl    = ALU_SUB;
        ill = (f3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        c.reg_write  = 1'b1;
        c.jump       = 1'b1;
        c.result_src = RES_PC4;
        c.imm_src    = IMM_J;
      end
      OPC_JALR: begin
        c.reg_write     = 1'b1;
        c.jump          = 1'b1;
        c.result_src    = RES_PC4;
        c.imm_src       = IMM_I;
        c.alu_src_b     = 1'b1;
        c.pc_target_src = 1'b1;
      end
      OPC_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.imm_src   = IMM_U;
        c.alu_ctrl  = ALU_PASSB;
      end
      OPC_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 1'b1;
        c.imm_src   = IMM_U;
      end
      OPC_OPIMM: begin
        c.reg_write = 1'b1;
        c.alu_src_b = 1'b1;
        c.imm_src   = IMM_I;
        c.alu_ctrl  = alu_base(f3, (f3 == 3'b101) && instr[30]);
        // Shift-immediate encodings reuse imm[11:5] as funct7.
        if (f3 == 3'b001) ill = (f7 != 7'b0000000);
        if (f3 == 3'b101) ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_OP: begin
        c.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          c.alu_ctrl = alu_base(f3, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          c.alu_ctrl = alu_base(f3, 1'b1);
`ifdef RV32M_EN
        end else if (f7 == 7'b0000001) begin
          c.alu_ctrl = ALU_MUL + {2'b00, f3};
          c.is_div   = f3[2];
`endif
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      c         = '0;
      c.illegal = 1'b1;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// One-entry registered decode stage, 1-cycle latency; valid/ready both sides, full
// throughput; divide ops stall on divider occupancy (RV32M_EN), flush drops the entry.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output ctrl_t           out_ctrl,
  output logic            div_busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;
  ctrl_t  dec_ctrl;
  logic   stall;
  logic   out_fire;
  logic   in_fire;

  ctrl_decode u_decode (
    .instr (in_instr),
    .ctrl  (dec_ctrl)
  );

  assign stall     = out_ctrl.is_div & div_busy;
  assign out_valid = (state == FULL) & ~stall;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ~flush & ((state == EMPTY) | out_fire);
  assign in_fire   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_ctrl  <= '0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else if (in_fire) begin
      state     <= FULL;
      out_ctrl  <= dec_ctrl;
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end else if (out_fire) begin
      state <= EMPTY;
    end
  end

`ifdef RV32M_EN
  localparam logic [5:0] DIV_LOAD = 6'(DIV_LAT);

  logic [5:0] div_cnt;
  assign div_busy = (div_cnt != 6'd0);

  // A flushed divide never reached the divider, so it does not reload the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 6'd0;
    end else if (out_fire && !flush && out_ctrl.is_div) begin
      div_cnt <= DIV_LOAD;
    end else if (div_cnt != 6'd0) begin
      div_cnt <= div_cnt - 6'd1;
    end
  end
`else
  assign div_busy = 1'b0;

  logic unused_div_lat;
  assign unused_div_lat = ^DIV_LAT;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe; divider checks run when RV32M_EN is defined.
module tb_decode_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  ctrl_t           out_ctrl;
  logic            div_busy;

  decode_ctrl_pipe #(.XLEN(XLEN), .DIV_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl),
    .div_busy  (div_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    ctrl_t           ctrl;
  } item_t;

  localparam ctrl_t C_ILL   = '{illegal:1'b1, default:'0};
  localparam ctrl_t C_ADDI  = '{reg_write:1'b1, alu_src_b:1'b1, default:'0};
  localparam ctrl_t C_LW    = '{reg_write:1'b1, alu_src_b:1'b1, result_src:RES_MEM,
                                mem_size:2'b10, mem_signed:1'b1, default:'0};
  localparam ctrl_t C_SW    = '{mem_write:1'b1, alu_src_b:1'b1, imm_src:IMM_S,
                                mem_size:2'b10, default:'0};
  localparam ctrl_t C_BEQ   = '{branch:1'b1, imm_src:IMM_B, alu_ctrl:ALU_SUB, default:'0};
  localparam ctrl_t C_BLT   = '{branch:1'b1, imm_src:IMM_B, branch_type:3'b100,
                                alu_ctrl:ALU_SUB, default:'0};
  localparam ctrl_t C_JAL   = '{reg_write:1'b1, jump:1'b1, result_src:RES_PC4,
                                imm_src:IMM_J, default:'0};
  localparam ctrl_t C_JALR  = '{reg_write:1'b1, jump:1'b1, result_src:RES_PC4,
                                alu_src_b:1'b1, pc_target_src:1'b1, default:'0};
  localparam ctrl_t C_LUI   = '{reg_write:1'b1, alu_src_b:1'b1, imm_src:IMM_U,
                                alu_ctrl:ALU_PASSB, default:'0};
  localparam ctrl_t C_AUIPC = '{reg_write:1'b1, alu_src_a:1'b1, alu_src_b:1'b1,
                                imm_src:IMM_U, default:'0};
  localparam ctrl_t C_SUB   = '{reg_write:1'b1, alu_ctrl:ALU_SUB, default:'0};
  localparam ctrl_t C_SRAI  = '{reg_write:1'b1, alu_src_b:1'b1, alu_ctrl:ALU_SRA, default:'0};
`ifdef RV32M_EN
  localparam ctrl_t C_MUL   = '{reg_write:1'b1, alu_ctrl:ALU_MUL, default:'0};
  localparam ctrl_t C_DIV   = '{reg_write:1'b1, alu_ctrl:ALU_DIV, is_div:1'b1, default:'0};
`else
  localparam ctrl_t C_MUL   = C_ILL;
`endif

  item_t           sb[$];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              c0;
  logic [XLEN-1:0] pc_next = 32'h100;
  logic [XLEN-1:0] last_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] ins, input ctrl_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_next;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", {127'd0, in_ready}, 128'd1);
    end else begin
      sb.push_back('{ins, pc_next, e});
    end
    last_pc = pc_next;
    pc_next = pc_next + 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_zero_outputs();
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_ctrl",  {103'd0, out_ctrl}, 128'd0);
    chk("rst_out_instr", {96'd0, out_instr}, 128'd0);
    chk("rst_out_pc",    {96'd0, out_pc}, 128'd0);
    chk("rst_div_busy",  {127'd0, div_busy}, 128'd0);
  endtask

  // Monitor: every accepted output must match the oldest expected item.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", {96'd0, out_instr}, 128'd0);
        end else begin
          e = sb.pop_front();
          chk("out_item", {39'd0, out_instr, out_pc, out_ctrl}, {39'd0, e});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", {127'd0, in_ready}, 128'd1);

    // ADDI visible one cycle after acceptance, then a back-to-back stream.
    c0 = cyc;
    send(32'h00500093, C_ADDI);
    chk("addi_valid", {127'd0, out_valid}, 128'd1);
    send(32'h0040A103, C_LW);
    send(32'h0020A423, C_SW);
    send(32'h00208463, C_BEQ);
    send(32'h010000EF, C_JAL);
    send(32'h000100E7, C_JALR);
    send(32'h123451B7, C_LUI);
    send(32'h00001217, C_AUIPC);
    send(32'h402082B3, C_SUB);
    send(32'h4030D093, C_SRAI);
    send(32'h0000007F, C_ILL);
    send(32'h0020B423, C_ILL);
    send(32'h0000B003, C_ILL);
    send(32'h0020A463, C_ILL);
    send(32'h02208033, C_MUL);
    send(32'h0020C463, C_BLT);
    chk("stream_cycles", 128'(cyc - c0), 128'd16);

    // Downstream stall for 3 cycles with a pending input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00700113;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready",  {127'd0, in_ready}, 128'd0);
      chk("hold_out_valid", {127'd0, out_valid}, 128'd1);
      chk("hold_out_instr", {96'd0, out_instr}, {96'd0, 32'h0020C463});
      chk("hold_out_pc",    {96'd0, out_pc}, {96'd0, last_pc});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00700113, C_ADDI);
    @(posedge clk);
    #1;

    // Flush while FULL with out_ready high; a new input in that cycle is dropped.
    out_ready = 1'b0;
    send(32'h00500093, C_ADDI);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0040A103;
    @(negedge clk);
    chk("flush_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_empty_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_empty_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;

`ifdef RV32M_EN
    // DIV then DIV: second waits out 4 busy cycles after the first fires.
    send(32'h0220C0B3, C_DIV);
    send(32'h0220C0B3, C_DIV);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("div_busy_on", {127'd0, div_busy}, 128'd1);
      chk("div_stalled", {127'd0, out_valid}, 128'd0);
    end
    @(negedge clk);
    chk("div2_valid",  {127'd0, out_valid}, 128'd1);
    chk("div_busy_off", {127'd0, div_busy}, 128'd0);
    @(posedge clk);
    #1;

    // Flush does not clear a running divider count.
    out_ready = 1'b0;
    send(32'h00500093, C_ADDI);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_busy_a", {127'd0, div_busy}, 128'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    chk("flush_div_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_busy_b", {127'd0, div_busy}, 128'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_expired", {127'd0, div_busy}, 128'd0);

    // Reset during a divide stall, then a divide issues at once.
    send(32'h0220C0B3, C_DIV);
    send(32'h0220C0B3, C_DIV);
    @(negedge clk);
    chk("pre_rst_stall", {127'd0, out_valid}, 128'd0);
    #2 rst = 1'b1;
    #1 chk_zero_outputs();
    sb.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    send(32'h0220C0B3, C_DIV);
    chk("post_rst_div_valid", {127'd0, out_valid}, 128'd1);
`else
    // Reset while an instruction is held, then normal issue resumes.
    out_ready = 1'b0;
    send(32'h00500093, C_ADDI);
    @(negedge clk);
    chk("pre_rst_hold", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs();
    sb.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h02208033, C_ILL);
    chk("post_rst_valid", {127'd0, out_valid}, 128'd1);
`endif

    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
